// File: rtl/mseq_receiver.sv
// Purpose : receive end of the m-function serial link; locks onto the 31-chip LFSR sequence.
// Latency : bit_valid and all state update 3 CLK_50MHZ cycles after each sclk rise.
// Backpressure: none; every detected sclk rise is consumed, there is no stall path.
//
// Ports:
//   CLK_50MHZ, RST      system clock, asynchronous active-high reset
//   sclk, in_fun        transmitter bit clock and serial data (asynchronous)
//   bit_valid           one-cycle pulse per received bit
//   locked, data        lock flag and recovered phase index (0 when unlocked)
//   buff_rd             last 31 raw received bits, bit 0 newest
//   err_cnt             saturating mispredicted-bit count
//
// Optional feature macro: MSEQ_RX_ERRCNT_EN (builds the err_cnt counter;
// without it err_cnt is tied to zero).

module mseq_receiver #(
    parameter int                LFSR_W   = 5,
    parameter logic [LFSR_W-1:0] TAPS     = 5'b10100,
    parameter logic [LFSR_W-1:0] SEED     = 5'b00001,
    parameter int                LOCK_CNT = 8,
    parameter int                ERR_MAX  = 3
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic        sclk,
    input  logic        in_fun,
    output logic        bit_valid,
    output logic        locked,
    output logic [7:0]  data,
    output logic [30:0] buff_rd,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]        FILL_N  = 8'(LFSR_W);
    localparam logic [7:0]        MATCH_N = 8'(LOCK_CNT);
    localparam logic [7:0]        MISS_N  = 8'(ERR_MAX);
    // Last phase index of the period (2^LFSR_W - 2).
    localparam logic [LFSR_W-1:0] PH_MAX  = {{(LFSR_W-1){1'b1}}, 1'b0};

    state_t r_state, w_state_nx;

    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_din_s1, r_din_s2;
    logic r_bit_valid;

    logic [LFSR_W-1:0] r_win,  w_win_nx;
    logic [LFSR_W-1:0] r_phase, w_phase_nx;
    logic [7:0]        r_fill, w_fill_nx;
    logic [7:0]        r_match_cnt, w_match_nx;
    logic [7:0]        r_miss_cnt, w_miss_nx;
    logic [30:0]       r_buff;

    logic              w_stb;
    logic              w_rx_bit;
    logic              w_pred;
    logic              w_match;
    logic [LFSR_W-1:0] w_win_rx;
    logic [LFSR_W-1:0] w_win_pd;

    // Rising edge of the synchronised bit clock; data rides the same 2-FF depth.
    assign w_stb    = r_sclk_s2 & ~r_sclk_s3;
    assign w_rx_bit = r_din_s2;
    assign w_pred   = ^(r_win & TAPS);
    assign w_match  = (w_rx_bit == w_pred);
    assign w_win_rx = {r_win[LFSR_W-2:0], w_rx_bit};
    assign w_win_pd = {r_win[LFSR_W-2:0], w_pred};

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state <= ACQ;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_win_nx   = r_win;
        w_fill_nx  = r_fill;
        w_match_nx = r_match_cnt;
        w_miss_nx  = r_miss_cnt;
        w_phase_nx = r_phase;

        if (w_stb) begin
            case (r_state)
                ACQ: begin
                    w_win_nx = w_win_rx;
                    if (r_fill + 8'd1 >= FILL_N) begin
                        // All-zero window is the LFSR lock-up state: refill.
                        w_fill_nx = 8'd0;
                        if (w_win_rx != '0) begin
                            w_state_nx = TRACK;
                            w_match_nx = 8'd0;
                        end
                    end else begin
                        w_fill_nx = r_fill + 8'd1;
                    end
                end
                TRACK: begin
                    w_win_nx = w_win_rx;
                    if (w_match) begin
                        if (r_match_cnt + 8'd1 >= MATCH_N) begin
                            w_state_nx = LOCKED;
                            w_miss_nx  = 8'd0;
                        end else begin
                            w_match_nx = r_match_cnt + 8'd1;
                        end
                    end else begin
                        w_state_nx = ACQ;
                        w_fill_nx  = 8'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the window follows the local prediction, so
                    // isolated chip errors do not disturb phase.
                    w_win_nx = w_win_pd;
                    if (w_match) begin
                        w_miss_nx = 8'd0;
                    end else if (r_miss_cnt + 8'd1 >= MISS_N) begin
                        w_state_nx = ACQ;
                        w_fill_nx  = 8'd0;
                        w_miss_nx  = 8'd0;
                    end else begin
                        w_miss_nx = r_miss_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nx = ACQ;
                    w_fill_nx  = 8'd0;
                end
            endcase

            if (w_win_nx == SEED) begin
                w_phase_nx = '0;
            end else if (r_phase == PH_MAX) begin
                w_phase_nx = '0;
            end else begin
                w_phase_nx = r_phase + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_s3   <= 1'b0;
            r_din_s1    <= 1'b0;
            r_din_s2    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_win       <= '0;
            r_phase     <= '0;
            r_fill      <= 8'd0;
            r_match_cnt <= 8'd0;
            r_miss_cnt  <= 8'd0;
            r_buff      <= 31'd0;
        end else begin
            r_sclk_s1   <= sclk;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_s3   <= r_sclk_s2;
            r_din_s1    <= in_fun;
            r_din_s2    <= r_din_s1;
            r_bit_valid <= w_stb;
            r_win       <= w_win_nx;
            r_phase     <= w_phase_nx;
            r_fill      <= w_fill_nx;
            r_match_cnt <= w_match_nx;
            r_miss_cnt  <= w_miss_nx;
            if (w_stb) begin
                r_buff <= {r_buff[29:0], w_rx_bit};
            end
        end
    end

`ifdef MSEQ_RX_ERRCNT_EN
    logic       w_mispred;
    logic [7:0] r_err_cnt;

    assign w_mispred = w_stb && !w_match &&
                       ((r_state == TRACK) || (r_state == LOCKED));

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_err_cnt <= 8'd0;
        end else if (w_mispred && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign bit_valid = r_bit_valid;
    assign locked    = (r_state == LOCKED);
    assign data      = locked ? {{(8-LFSR_W){1'b0}}, r_phase} : 8'd0;
    assign buff_rd   = r_buff;

endmodule

// File: doc/mseq_receiver.md
Name: mseq_receiver

Overview:
- Receive end of the m-function serial link.
- Samples the transmitter's serial m-sequence (`in_fun`) on the rising edges of the transmitter bit clock (`sclk`). It runs in the `CLK_50MHZ` domain.
- Self-synchronises to the 31-chip sequence from the 5-stage LFSR and reports lock, the recovered phase index as `data`, and the last 31 received bits.
- Sits downstream of the m-sequence generator, on the far side of the link.

Parameters:
- LFSR_W, 5, LFSR length; sequence period is 2^LFSR_W-1 = 31.
- TAPS, 5'b10100, recurrence taps on the bit window: predicted bit = ^(win & TAPS), i.e. a[n+5] = a[n] ^ a[n+2].
- SEED, 5'b00001, window value that defines phase index 0.
- LOCK_CNT, 8, consecutive correct predictions in TRACK needed to declare lock.
- ERR_MAX, 3, consecutive mispredictions in LOCKED that drop lock.

Ports:
- CLK_50MHZ  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- sclk  in  1  transmitter bit clock, asynchronous to CLK_50MHZ.
- in_fun  in  1  serial m-sequence data, stable around sclk rise.
- bit_valid  out  1  one-cycle pulse per received bit.
- locked  out  1  high while in LOCKED.
- data  out  8  phase index 0..30 while locked, 0 otherwise.
- buff_rd  out  31  last 31 received raw bits; bit 0 is newest.
- err_cnt  out  8  mispredicted-bit count (see Optional Feature).

Behaviour:
- Input sampling:
  - sclk and in_fun each pass through a 2-FF synchroniser.
  - A rising edge of synchronised sclk, detected with a third FF, is the sample strobe; the bit sampled is the synchronised in_fun.
  - bit_valid is asserted 3 CLK_50MHZ cycles after sclk rises and lasts exactly 1 cycle. All registers below update only on that strobe.
- Window: `win[LFSR_W-1:0]`, where win[0] is the newest bit.
  - buff_rd <= {buff_rd[29:0], rx_bit} on every strobe, in all states.
- FSM, 2-bit, states ACQ, TRACK, LOCKED:
  - ACQ:
    - Shift rx_bit into win and count fill.
    - After LFSR_W bits, go to TRACK with match_cnt = 0.
    - If win == 0 (invalid LFSR state), stay in ACQ and restart the fill count.
  - TRACK:
    - pred = ^(win & TAPS).
    - On rx_bit == pred: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt = 0.
    - On mismatch: go to ACQ with fill = 0.
    - win shifts in rx_bit.
  - LOCKED (flywheel):
    - win shifts in pred, not rx_bit.
    - A mismatch increments miss_cnt; a match clears it.
    - When miss_cnt reaches ERR_MAX, go to ACQ. `locked` falls on the same strobe.
- Phase counter:
  - Increments modulo 31 (30 -> 0) on each strobe.
  - Forced to 0 on any strobe whose post-shift win == SEED.
  - data = {3'b0, phase} when locked, else 8'd0.
- Simultaneous events: the FSM transition and the win/phase update occur on the same strobe. The value of `locked` on that cycle reflects the new state.
- Reset:
  - Any RST assertion, including mid-frame, returns to ACQ immediately.
  - Resets all counters and synchroniser FFs to 0.
  - Outputs at reset: bit_valid = 0, locked = 0, data = 0, buff_rd = 0, err_cnt = 0.
- sclk behaviour: sclk high for fewer than 2 CLK_50MHZ cycles may be missed. The required sclk period is at least 4 CLK_50MHZ cycles.

Optional Feature:
- Macro: MSEQ_RX_ERRCNT_EN.
- With the macro defined:
  - err_cnt counts every mispredicted bit in TRACK and LOCKED.
  - It saturates at 8'hFF and is cleared only by RST.
- Without the macro: err_cnt is tied to 8'd0 and no counter logic is built.

Test Plan:
- Clean stream: transmitter sequence from state 00001, sclk period 10 CLK_50MHZ cycles.
  - locked rises on strobe 5+8 = 13.
  - data increments by 1 per bit and wraps 30 -> 0.
  - bit_valid arrives exactly 3 cycles after each sclk rise.
- Single flipped chip while locked: locked stays 1 and data continues unchanged. With MSEQ_RX_ERRCNT_EN, err_cnt = 1.
- 3 consecutive flipped chips while locked: locked falls on the 3rd bad strobe and data = 0. Re-lock happens 13 strobes later.
- All-zero input: stays in ACQ, locked = 0 indefinitely, buff_rd = 0.
- RST pulsed mid-TRACK: all outputs 0 on the next cycle. After release, acquisition restarts and locked rises after 13 further bits.
- Bit error in TRACK, at the 4th prediction: returns to ACQ with no lock. Lock is then reached only after 5 + 8 further clean bits.
